// File: rtl/nibble_loader_pkg.sv
// nibble_loader_pkg: shared widths and FSM encoding for the nibble loader.
// Holds DW/NDIG/W, the digit counter width, and the state enum.
package nibble_loader_pkg;

    localparam int DW   = 4;
    localparam int NDIG = 3;
    localparam int W    = DW * NDIG;
    localparam int CW   = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_loader_shift_stage.sv
// nibble_shift_stage: W-bit staging shift register, DW bits shifted in at LSB.
// Ports: clk, i_rst_n (sync active-low), i_clear, i_shift, i_din, o_q (parallel out).
module nibble_shift_stage
    import nibble_loader_pkg::*;
(
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_shift,
    input  logic [DW-1:0] i_din,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;

    // Clear wins over shift so a completing load can empty the stage.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {r_q[W-DW-1:0], i_din};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/nibble_loader.sv
// nibble_loader: assembles a 12-bit word from three 4-bit digits
// and drives L plus a one-cycle en strobe.
module nibble_loader
  import nibble_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] digit,
  input  logic          digit_valid,
  input  logic          cancel,
  output logic [W-1:0]  L,
  output logic          en,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output logic          err
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  r_L;
  logic          r_en;
  logic          w_shift;
  logic          w_clear;
  logic          w_load;
  logic [W-1:0]  w_stage;

`ifdef NIBBLE_TIMEOUT_EN
  logic [7:0]    r_idle;
  logic          r_err;
  logic          w_timeout;
  logic          w_to;

  assign w_timeout = (r_state == S_COLLECT) &&
                     (r_idle == 8'(TIMEOUT_CYCLES - 1));
`endif

  nibble_shift_stage u_stage (
    .clk     (clk),
    .i_rst_n (clr),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_din   (digit),
    .o_q     (w_stage)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_shift   = 1'b0;
    w_clear   = 1'b0;
    w_load    = 1'b0;
`ifdef NIBBLE_TIMEOUT_EN
    w_to      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (digit_valid) begin
          w_shift   = 1'b1;
          w_cnt_nxt = CW'(1);
          w_next    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          w_clear   = 1'b1;
          w_cnt_nxt = '0;
          w_next    = S_IDLE;
`ifdef NIBBLE_TIMEOUT_EN
        end else if (w_timeout) begin
          w_clear   = 1'b1;
          w_cnt_nxt = '0;
          w_to      = 1'b1;
          w_next    = S_IDLE;
`endif
        end else if (digit_valid) begin
          if (r_cnt == CW'(NDIG - 1)) begin
            w_load    = 1'b1;
            w_clear   = 1'b1;
            w_cnt_nxt = '0;
            w_next    = S_LOAD;
          end else begin
            w_shift   = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_LOAD: begin
        w_cnt_nxt = '0;
        w_next    = S_IDLE;
      end
      default: begin
        w_cnt_nxt = '0;
        w_next    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_L     <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_load;
      if (w_load) begin
        r_L <= (w_stage << DW) | W'(digit);
      end
    end
  end

`ifdef NIBBLE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_idle <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_to;
      if (r_state != S_COLLECT ||
          w_next != S_COLLECT || w_shift) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign L    = r_L;
  assign en   = r_en;
  assign cnt  = r_cnt;
  assign busy = (r_state != S_IDLE);

endmodule

// File: doc/nibble_loader.md
Name: nibble_loader

Overview:
- Upstream stage of the 12-bit transparent D register. Assembles a 12-bit product word (price/expiry code) from three 4-bit digits entered one at a time, MSB digit first.
- Drives the register's data bus L and a one-cycle load strobe en.
- Partial entries never disturb L. The register sees a new value only when a full word is complete.

Parameters:
- DW, 4, bits per digit.
- NDIG, 3, digits per word; word width W = DW*NDIG = 12.
- TIMEOUT_CYCLES, 255, max idle cycles between digits mid-entry (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  synchronous, active-low reset; sampled on rising clk.
- digit  in  DW  digit value; any 4-bit code is legal (0x0..0xF).
- digit_valid  in  1  digit present this cycle; single-cycle qualifier.
- cancel  in  1  abort the current entry.
- L  out  W  word bus to register; holds the last completed word.
- en  out  1  load strobe to register; high exactly one cycle per completed word.
- busy  out  1  high while a word is partially entered or loading.
- cnt  out  2  number of digits captured in the current entry (0..NDIG-1).
- err  out  1  timeout abort pulse; constant 0 without NIBBLE_TIMEOUT_EN.

Behaviour:
- Reset (clr=0 at a rising edge) applies to every state:
  - State goes to IDLE; L=0, en=0, busy=0, cnt=0, err=0; staging register cleared.
  - Reset mid-entry discards the partial word; L still reads 0 afterwards.
- FSM states: IDLE, COLLECT, LOAD.
  - IDLE: on digit_valid, shift the digit into the staging register, cnt=1, go to COLLECT.
  - COLLECT: on digit_valid, shift the digit in and increment cnt. On the NDIG-th digit, copy staging {d2,d1,d0} to L, set en=1, go to LOAD.
  - LOAD: lasts one cycle; en drops at the next edge; return to IDLE, cnt=0.
- Latency: L updates and en asserts on the same edge that captures the third digit. L is stable the whole en-high cycle and stays held until the next completed word.
- Digit order: first digit lands in L[11:8], last digit in L[3:0].
- busy = (state != IDLE).
- Priority when signals coincide: clr > cancel > timeout > digit_valid.
  - cancel in COLLECT: back to IDLE, cnt=0, staging cleared, L unchanged, no en.
  - cancel in IDLE or LOAD: no effect; a load already issued is not retracted.
- digit_valid during LOAD is ignored; the digit is dropped and no new entry starts.
- Back-to-back digits on consecutive cycles are legal; the minimum word period is NDIG+1 cycles.
- No wrap-around: cnt never exceeds NDIG-1 at any observable edge.

Optional Feature:
- Macro: NIBBLE_TIMEOUT_EN.
- Defined:
  - An idle counter (8 bits, sized to TIMEOUT_CYCLES) runs in COLLECT. It resets on each accepted digit.
  - On reaching TIMEOUT_CYCLES without a digit: go to IDLE, cnt=0, staging cleared, L unchanged, err=1 for one cycle.
  - A digit_valid arriving on the timeout cycle is dropped.
- Undefined: no counter; COLLECT waits indefinitely; err tied to 0.

Decomposition:
- Shared package holds:
  - W, DW, NDIG constants.
  - The state encoding (IDLE=2'd0, COLLECT=2'd1, LOAD=2'd2).
- One sub-module is natural: nibble_shift_stage, a W-bit staging shift register with synchronous clear, shift-in of DW bits, and parallel out. The FSM, cnt, output register and timeout logic stay in nibble_loader.

Test Plan:
- Basic load: after reset, digits 0x0, 0xC, 0x4 with digit_valid on non-consecutive cycles -> en pulses one cycle; L=12'b000011000100; L holds after en drops; busy returns to 0.
- Back-to-back words: digits D,1,1 on consecutive cycles, then 7,9,5 -> en pulses twice; L=12'hD11, then 12'h795; a digit_valid offered in LOAD is dropped.
- Cancel: L=12'h795, enter 0x1, 0x2, then cancel simultaneous with a third digit -> no en; L stays 12'h795; cnt=0; the next entry 0xA,0xB,0xC -> L=12'hABC.
- Reset mid-entry: two digits entered, clr=0 for one edge -> L=0, cnt=0, busy=0, en=0; a following full entry loads correctly.
- Timeout (NIBBLE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): one digit entered, then 8 idle cycles -> err pulses one cycle; state IDLE; L unchanged; without the macro, the same stimulus leaves cnt=1 and busy=1 indefinitely.
